// File: rtl/i2c_regfile_slave_if.sv
// rtl/i2c_regfile_slave_if.sv - I2C pad-side bus bundle for i2c_regfile_slave
// sda_in is the resolved open-drain line; sda_oe=1 pulls SDA low.
interface i2c_regfile_slave_if;
   logic scl_in;
   logic sda_in;
   logic sda_oe;

   modport master (output scl_in, output sda_in, input sda_oe);
   modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_regfile_slave.sv
// rtl/i2c_regfile_slave.sv - I2C slave with sub-addressed, auto-incrementing byte register file
// Define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter on synchronised SCL/SDA.
module i2c_regfile_slave #(
   parameter int         NREGS     = 12,
   parameter logic [6:0] DEV_ADDR  = 7'h70,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               rst_n,
   i2c_regfile_slave_if.slave bus,
   output logic [NREGS*8-1:0] regs,
   output logic [NREGS-1:0]   wr_pulse,
   output logic               busy
);
   localparam int         IW   = $clog2(NREGS);
   localparam logic [7:0] NR8  = 8'(NREGS);
   localparam logic [7:0] LAST = 8'(NREGS - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic             scl_v, sda_v;
   logic             scl_p_q, scl_p_d, sda_p_q, sda_p_d;
   logic             scl_rise, scl_fall, start_det, stop_det;
   logic [2:0]       cnt_q, cnt_d;
   logic [6:0]       sh_q, sh_d;
   logic [7:0]       ptr_q, ptr_d, ptr_next, rx_byte, rd_byte;
   logic             rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
   logic             in_range;
   logic [IW-1:0]    idx;
   logic [7:0]       regs_q [NREGS];
   logic [7:0]       regs_d [NREGS];
   logic [NREGS-1:0] wr_pulse_q, wr_pulse_d;

   assign scl_sync_d = {scl_sync_q[0], bus.scl_in};
   assign sda_sync_d = {sda_sync_q[0], bus.sda_in};

`ifdef I2C_GLITCH_FILTER_EN
   // Filtered level follows the input only after three equal consecutive samples.
   logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

   always_comb begin
      scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_d  = scl_flt_q;
      sda_flt_d  = sda_flt_q;
      if (scl_hist_q == {2{scl_sync_q[1]}}) scl_flt_d = scl_sync_q[1];
      if (sda_hist_q == {2{sda_sync_q[1]}}) sda_flt_d = sda_sync_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_flt_q  <= 1'b1;
         sda_flt_q  <= 1'b1;
      end else begin
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         scl_flt_q  <= scl_flt_d;
         sda_flt_q  <= sda_flt_d;
      end
   end

   assign scl_v = scl_flt_q;
   assign sda_v = sda_flt_q;
`else
   assign scl_v = scl_sync_q[1];
   assign sda_v = sda_sync_q[1];
`endif

   assign scl_p_d   = scl_v;
   assign sda_p_d   = sda_v;
   assign scl_rise  = scl_v & ~scl_p_q;
   assign scl_fall  = ~scl_v & scl_p_q;
   assign start_det = scl_v & scl_p_q & ~sda_v & sda_p_q;
   assign stop_det  = scl_v & scl_p_q & sda_v & ~sda_p_q;

   assign idx      = ptr_q[IW-1:0];
   assign in_range = (ptr_q < NR8);
   assign ptr_next = (ptr_q == LAST) ? 8'h00 : ptr_q + 8'd1;
   assign rd_byte  = in_range ? regs_q[idx] : 8'h00;
   assign rx_byte  = {sh_q, sda_v};

   // cnt counts SCL rises inside a byte; in ACK states 0/1 tells the first fall from the second.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      wr_pulse_d = '0;
      regs_d     = regs_q;
      if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d  = ADDR;
         cnt_d    = 3'd0;
         sda_oe_d = 1'b0;
      end else if (scl_rise) begin
         cnt_d = cnt_q + 3'd1;
         case (state_q)
            ADDR, SUB, WDATA: begin
               sh_d = rx_byte[6:0];
               if (cnt_q == 3'd7) begin
                  cnt_d = 3'd0;
                  if (state_q == ADDR) begin
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        state_d = ADDR_ACK;
                        rw_d    = rx_byte[0];
                        busy_d  = 1'b1;
                     end else begin
                        state_d = IGNORE;
                     end
                  end else if (state_q == SUB) begin
                     ptr_d   = rx_byte;
                     state_d = SUB_ACK;
                  end else begin
                     state_d = WDATA_ACK;
                     if (in_range) begin
                        regs_d[idx]     = rx_byte;
                        wr_pulse_d[idx] = 1'b1;
                        ptr_d           = ptr_next;
                     end
                  end
               end
            end
            RDATA: begin
               if (cnt_q == 3'd7) begin
                  cnt_d   = 3'd0;
                  state_d = RDATA_ACK;
                  if (in_range) ptr_d = ptr_next;
               end
            end
            RDATA_ACK: begin
               if (sda_v) state_d = IGNORE;
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ADDR_ACK, SUB_ACK, WDATA_ACK: begin
               if (cnt_q == 3'd0) begin
                  sda_oe_d = 1'b1;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = 3'd0;
                  if (state_q == ADDR_ACK && rw_q) begin
                     state_d  = RDATA;
                     sh_d     = rd_byte[6:0];
                     sda_oe_d = ~rd_byte[7];
                  end else if (state_q == ADDR_ACK) begin
                     state_d = SUB;
                  end else begin
                     state_d = WDATA;
                  end
               end
            end
            RDATA: begin
               sh_d     = {sh_q[5:0], 1'b0};
               sda_oe_d = ~sh_q[6];
            end
            RDATA_ACK: begin
               if (cnt_q == 3'd0) begin
                  sda_oe_d = 1'b0;
               end else begin
                  state_d  = RDATA;
                  cnt_d    = 3'd0;
                  sh_d     = rd_byte[6:0];
                  sda_oe_d = ~rd_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
         cnt_q      <= 3'd0;
         sh_q       <= 7'd0;
         ptr_q      <= 8'd0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= '0;
         for (int k = 0; k < NREGS; k++) regs_q[k] <= RESET_VAL;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_p_q    <= scl_p_d;
         sda_p_q    <= sda_p_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
      end
   end

   for (genvar k = 0; k < NREGS; k++) begin : g_flat
      assign regs[8*k +: 8] = regs_q[k];
   end

   assign bus.sda_oe = sda_oe_q;
   assign wr_pulse   = wr_pulse_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_regfile_slave.sv
// tb/tb_i2c_regfile_slave.sv - randomized bench for i2c_regfile_slave against a register-file model
// Builds with or without I2C_GLITCH_FILTER_EN; the glitch scenario runs only when it is defined.
module tb_i2c_regfile_slave;
   localparam int NREGS = 12;
   localparam int Q     = 5;

   logic clk = 1'b0, rst_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
   logic [NREGS*8-1:0] regs;
   logic [NREGS-1:0]   wr_pulse;
   logic               busy;

   int n_checks = 0, n_fail = 0;
   logic [7:0] mregs [NREGS];
   int mptr = 0;
   int wp_log[$];
   int wp_exp[$];

   i2c_regfile_slave_if bus();
   assign bus.scl_in = m_scl;
   assign bus.sda_in = m_sda & ~bus.sda_oe;

   i2c_regfile_slave #(.NREGS(NREGS), .DEV_ADDR(7'h70), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .regs(regs), .wr_pulse(wr_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      for (int k = 0; k < NREGS; k++) if (wr_pulse[k]) wp_log.push_back(k);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- model ----------------
   function automatic void m_write(input logic [7:0] b);
      if (mptr < NREGS) begin
         mregs[mptr] = b;
         wp_exp.push_back(mptr);
         mptr = (mptr + 1) % NREGS;
      end
   endfunction

   function automatic logic [7:0] m_read();
      logic [7:0] r = 8'h00;
      if (mptr < NREGS) begin
         r    = mregs[mptr];
         mptr = (mptr + 1) % NREGS;
      end
      return r;
   endfunction

   function automatic logic [NREGS*8-1:0] m_flat();
      logic [NREGS*8-1:0] f;
      for (int k = 0; k < NREGS; k++) f[8*k +: 8] = mregs[k];
      return f;
   endfunction

   function automatic bit seq_ok();
      if (wp_log.size() != wp_exp.size()) return 1'b0;
      foreach (wp_log[i]) if (wp_log[i] != wp_exp[i]) return 1'b0;
      return 1'b1;
   endfunction

   // ---------------- bus master ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start;
      m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop;
      m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
   endtask

   task automatic i2c_bit(input logic v, output logic s);
      m_sda = v; tick(Q); m_scl = 1'b1; tick(Q);
      s = bus.sda_in; tick(Q); m_scl = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
      i2c_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nak, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, s);
         b[i] = s;
      end
      i2c_bit(nak, s);
   endtask

   task automatic do_write(input logic [7:0] sub, input logic [7:0] d[$],
                           output int acks, output logic busy_mid);
      logic a;
      acks = 0;
      wp_log.delete(); wp_exp.delete();
      i2c_start;
      write_byte(8'hE0, a); acks += int'(a); busy_mid = busy;
      write_byte(sub, a);   acks += int'(a); mptr = int'(sub);
      foreach (d[i]) begin
         write_byte(d[i], a); acks += int'(a);
         m_write(d[i]);
      end
      i2c_stop;
      tick(4);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      tick(3);
      n_checks++; if (regs !== {NREGS{8'h00}}) begin n_fail++; $display("FAIL reset_regs: got %h want all 00", regs); end
      n_checks++; if (wr_pulse !== '0) begin n_fail++; $display("FAIL reset_wr_pulse: got %h want 0", wr_pulse); end
      n_checks++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic test_write_basic;
      logic [7:0] d[$];
      int acks; logic bm;
      d = {8'hAA, 8'h55};
      do_write(8'h00, d, acks, bm);
      n_checks++; if (acks != 4) begin n_fail++; $display("FAIL basic_acks: got %0d want 4", acks); end
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL basic_regs: got %h want %h", regs, m_flat()); end
      n_checks++; if (!seq_ok()) begin n_fail++; $display("FAIL basic_wr_pulse: got %0d pulses want %0d", wp_log.size(), wp_exp.size()); end
      n_checks++; if (bm !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b want 1", bm); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_stop: got %b want 0", busy); end
   endtask

   task automatic test_wrap;
      logic [7:0] d[$];
      int acks; logic bm;
      d = {8'h01, 8'h02};
      do_write(8'h0B, d, acks, bm);
      n_checks++; if (acks != 4) begin n_fail++; $display("FAIL wrap_acks: got %0d want 4", acks); end
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL wrap_regs: got %h want %h", regs, m_flat()); end
      n_checks++; if (!seq_ok()) begin n_fail++; $display("FAIL wrap_wr_pulse: got %0d pulses want %0d", wp_log.size(), wp_exp.size()); end
   endtask

   task automatic test_read_all;
      logic [7:0] d[$];
      logic [7:0] b, e;
      int acks; logic bm, a;
      for (int i = 0; i < NREGS; i++) d.push_back(8'($urandom));
      do_write(8'h00, d, acks, bm);
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL fill_regs: got %h want %h", regs, m_flat()); end
      i2c_start;
      write_byte(8'hE0, a);
      write_byte(8'h00, a); mptr = 0;
      i2c_start;
      write_byte(8'hE1, a);
      n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack: got %b want 1", a); end
      for (int i = 0; i < NREGS; i++) begin
         read_byte(i == NREGS - 1, b);
         e = m_read();
         n_checks++; if (b !== e) begin n_fail++; $display("FAIL read_byte[%0d]: got %h want %h", i, b, e); end
      end
      n_checks++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nak: got %b want 0", bus.sda_oe); end
      i2c_stop;
      tick(4);
   endtask

   task automatic test_wrong_addr;
      logic a;
      i2c_start;
      write_byte(8'hE2, a);
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack: got %b want 0", a); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b want 0", busy); end
      write_byte(8'($urandom), a);
      n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_data_ack: got %b want 0", a); end
      i2c_stop;
      tick(4);
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL wrong_addr_regs: got %h want %h", regs, m_flat()); end
   endtask

   task automatic test_out_of_range;
      logic [7:0] d[$];
      logic [7:0] b, e;
      int acks; logic bm, a;
      d = {8'h77};
      do_write(8'h0C, d, acks, bm);
      n_checks++; if (acks != 3) begin n_fail++; $display("FAIL oor_acks: got %0d want 3", acks); end
      n_checks++; if (wp_log.size() != 0) begin n_fail++; $display("FAIL oor_wr_pulse: got %0d pulses want 0", wp_log.size()); end
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL oor_regs: got %h want %h", regs, m_flat()); end
      i2c_start;
      write_byte(8'hE1, a);
      for (int i = 0; i < 2; i++) begin
         read_byte(i == 1, b);
         e = m_read();
         n_checks++; if (b !== e) begin n_fail++; $display("FAIL oor_read[%0d]: got %h want %h", i, b, e); end
      end
      i2c_stop;
      tick(4);
   endtask

   task automatic test_random_bursts;
      logic [7:0] d[$];
      logic [7:0] b, e, sub;
      int acks, n; logic bm, a;
      for (int it = 0; it < 6; it++) begin
         d.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) d.push_back(8'($urandom));
         sub = 8'($urandom_range(0, NREGS + 1));
         do_write(sub, d, acks, bm);
         n_checks++; if (acks != n + 2) begin n_fail++; $display("FAIL rnd_acks[%0d]: got %0d want %0d", it, acks, n + 2); end
         n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL rnd_regs[%0d]: got %h want %h", it, regs, m_flat()); end
         n_checks++; if (!seq_ok()) begin n_fail++; $display("FAIL rnd_wr_pulse[%0d]: got %0d pulses want %0d", it, wp_log.size(), wp_exp.size()); end
         sub = 8'($urandom_range(0, NREGS + 1));
         i2c_start;
         write_byte(8'hE0, a);
         write_byte(sub, a); mptr = int'(sub);
         i2c_start;
         write_byte(8'hE1, a);
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            e = m_read();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL rnd_read[%0d.%0d]: got %h want %h", it, i, b, e); end
         end
         i2c_stop;
         tick(4);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d[$];
      logic [7:0] data;
      int acks; logic bm, a, s;
      data = 8'hB6;
      i2c_start;
      write_byte(8'hE0, a);
      write_byte(8'h03, a);
      for (int i = 7; i >= 4; i--) i2c_bit(data[i], s);
      m_sda = data[3]; tick(Q); m_scl = 1'b1; tick(2);
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_sda_oe: got %b want 0", bus.sda_oe); end
      n_checks++; if (regs !== {NREGS{8'h00}}) begin n_fail++; $display("FAIL rstmid_regs: got %h want all 00", regs); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
      mptr = 0;
      m_sda = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(Q);
      m_scl = 1'b0;
      tick(Q);
      d = {8'hC3, 8'h3C};
      do_write(8'h05, d, acks, bm);
      n_checks++; if (acks != 4) begin n_fail++; $display("FAIL rstmid_after_acks: got %0d want 4", acks); end
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL rstmid_after_regs: got %h want %h", regs, m_flat()); end
      n_checks++; if (!seq_ok()) begin n_fail++; $display("FAIL rstmid_after_wr_pulse: got %0d pulses want %0d", wp_log.size(), wp_exp.size()); end
   endtask

`ifdef I2C_GLITCH_FILTER_EN
   task automatic test_glitch;
      logic [7:0] data;
      logic a, s;
      data = 8'($urandom);
      wp_log.delete(); wp_exp.delete();
      i2c_start;
      write_byte(8'hE0, a);
      write_byte(8'h02, a); mptr = 2;
      for (int i = 7; i >= 0; i--) begin
         if (i == 4) begin
            m_sda = data[i]; tick(Q); m_scl = 1'b1; tick(2);
            m_scl = 1'b0; tick(1); m_scl = 1'b1; tick(Q);
            m_scl = 1'b0; tick(Q);
         end else begin
            i2c_bit(data[i], s);
         end
      end
      i2c_bit(1'b1, s);
      m_write(data);
      n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL glitch_ack: got line %b want 0", s); end
      i2c_stop;
      tick(4);
      n_checks++; if (regs !== m_flat()) begin n_fail++; $display("FAIL glitch_regs: got %h want %h", regs, m_flat()); end
   endtask
`endif

   initial begin
      for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
      test_reset;
      test_write_basic;
      test_wrap;
      test_read_all;
      test_wrong_addr;
      test_out_of_range;
      test_random_bursts;
      test_reset_mid;
`ifdef I2C_GLITCH_FILTER_EN
      test_glitch;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
